shift_register_scheduler: RTL

Sequences the 4-bit shift-register datapath on behalf of two requesters. Each requester submits a command (parallel word, shift direction, fill bit, shift count). The block arbitrates round-robin and drives the shift register's load, serial and direction controls for one load cycle followed by N shift cycles. It then returns the final register contents to the winning requester with a one-cycle done pulse. It sits between the tt_um top-level pin decode and the shift register instance.

---
 rtl/shift_sched_pkg.sv | 17 +
 rtl/shift_register_scheduler_arb.sv | 35 +++
 rtl/shift_register_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift-register scheduler and its arbiter.
package shift_sched_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 3;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_register_scheduler_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester
// and only moves when the grant is actually taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  logic       r_last;
  logic [1:0] w_grant;

  // A lone requester always wins; on a tie the one not granted last goes first.
  always_comb begin
    w_grant = 2'b00;
    case (i_req)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (i_update) begin
      r_last <= w_grant[1];
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/shift_register_scheduler.sv
// Runs one load plus N shift cycles of the shift register for whichever of two
// requesters wins arbitration, then hands back the final contents with a done pulse.
module shift_register_scheduler
  import shift_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  input  logic [2*WIDTH-1:0]   req_data,
  input  logic [1:0]           req_dir,
  input  logic [1:0]           req_fill,
  input  logic [2*CNT_W-1:0]   req_count,
  output logic [1:0]           req_ack,
  output logic [1:0]           done,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 sr_load,
  output logic                 sr_serial,
  output logic                 sr_direction,
  output logic [WIDTH-1:0]     sr_parallel,
  input  logic [WIDTH-1:0]     sr_q
);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [WIDTH-1:0]   r_data;
  logic               r_dir;
  logic               r_fill;
  logic [CNT_W-1:0]   r_count;
  logic               r_idx;

  logic [1:0]         w_grant;
  logic [1:0]         w_ack;
  logic               w_xfer;
  logic               w_gidx;

  // Acks are offered only from IDLE, and are forced low while reset is held.
  assign w_ack  = ((r_state == IDLE) && !reset) ? w_grant : 2'b00;
  assign w_xfer = |(req_valid & w_ack);
  assign w_gidx = w_ack[1];

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    (req_valid),
    .i_update (w_xfer),
    .o_grant  (w_grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_dir   <= 1'b0;
      r_fill  <= 1'b0;
      r_count <= '0;
      r_idx   <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= req_data[w_gidx*WIDTH +: WIDTH];
      r_dir   <= req_dir[w_gidx];
      r_fill  <= req_fill[w_gidx];
      r_count <= req_count[w_gidx*CNT_W +: CNT_W];
      r_idx   <= w_gidx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // The counter holds the shifts still owed; leaving SHIFT at 1 gives exactly count edges.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_xfer) w_next_state = LOAD;
      end
      LOAD: begin
        if (r_count == '0) begin
          w_next_state = DONE;
        end else begin
          w_next_state = SHIFT;
          w_cnt_next   = r_count;
        end
      end
      SHIFT: begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) w_next_state = DONE;
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ack      = w_ack;
    done         = 2'b00;
    result       = '0;
    busy         = (r_state != IDLE);
    sr_load      = 1'b0;
    sr_serial    = 1'b0;
    sr_direction = 1'b0;
    sr_parallel  = '0;
    case (r_state)
      LOAD: begin
        sr_load      = 1'b1;
        sr_parallel  = r_data;
        sr_direction = r_dir;
        sr_serial    = r_fill;
      end
      SHIFT: begin
        sr_direction = r_dir;
        sr_serial    = r_fill;
      end
      DONE: begin
        done[r_idx] = 1'b1;
        result      = sr_q;
      end
      default: begin
      end
    endcase
  end

endmodule
